// File: rtl/referee_pkg.sv
// Shared definitions for the round-robin referee: default sizing, index and
// counter widths, FSM encoding and a small wrap-around increment helper.
package referee_pkg;

    localparam int N_DEF     = 4;   // number of source FIFOs
    localparam int W_DEF     = 12;  // data word width
    localparam int BURST_DEF = 4;   // max consecutive pops from one source

    localparam int IW = 3;          // index width, covers up to 8 sources
    localparam int BW = 4;          // burst counter width, covers BURST up to 15
    localparam int CW = 16;         // forwarded-word counter width

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next index after idx, wrapping back to 0 past the last of n sources.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end else begin
            return idx + IW'(1);
        end
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: returns the first eligible source at or after start,
// wrapping modulo N. Purely combinational.
module rr_select
    import referee_pkg::*;
#(
    parameter int N = N_DEF
)(
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Rotate the request vector so that bit 0 corresponds to start.
    logic [N-1:0] rot;

    assign rot = N'({eligible, eligible} >> start);

    // Lowest set bit of the rotated vector wins; map it back to a source index.
    always_comb begin : scan
        int sum;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(start) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                idx = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/rr_referee.sv
// Round-robin referee draining N source FIFOs into one downstream FIFO, with
// bounded bursts per source and a 2-cycle pop-to-push pipeline.
//
// Handshake: pop_out[i] is a one-cycle read strobe to source i, which must
// present the popped word on its data_in slice in the following cycle;
// push_out is a write strobe the downstream FIFO accepts unconditionally, so
// almost_full_in is the only back-pressure and must leave room for the two
// words that can already be in flight when it rises.
module rr_referee
    import referee_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int BURST = BURST_DEF
)(
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   empty_in,
    input  logic [N-1:0]   almost_empty_in,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   pop_out,
    input  logic           almost_full_in,
    output logic           push_out,
    output logic [W-1:0]   data_out,
    output logic [IW-1:0]  grant_idx,
    output logic [CW-1:0]  fwd_count
);

    localparam logic [N-1:0] ONE = N'(1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_ptr_nxt;
    logic [BW-1:0]   burst;
    logic [BW-1:0]   burst_nxt;
    logic [N-1:0]    pop_nxt;
    logic [N-1:0]    eligible;
    logic [N-1:0]    grant_oh;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   sel_start;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic            grant_ok;
    logic            pipe_vld;
    logic [IW-1:0]   pipe_idx;
    logic [W-1:0]    cap_word;

    // A source holding one word that is being popped right now looks
    // non-empty for one more cycle because its flags are registered, so it
    // must not be popped again back-to-back.
    assign eligible  = ~empty_in & ~(pop_out & almost_empty_in);
    assign grant_oh  = ONE << grant_idx;
    assign grant_ok  = (eligible & grant_oh) != '0;
    assign next_ptr  = wrap_inc(grant_idx, N);

    // From IDLE the search starts at the rr pointer; while granting, the
    // search for the replacement source starts just past the current one.
    assign sel_start = (state == IDLE) ? rr_ptr : next_ptr;

    rr_select #(.N(N)) u_select (
        .eligible (eligible),
        .start    (sel_start),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    // Next-state, next-grant and next-pop decision.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_idx;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst;
        pop_nxt    = '0;
        case (state)
            IDLE: begin
                if (!almost_full_in && sel_found) begin
                    state_nxt = GRANT;
                    grant_nxt = sel_idx;
                    burst_nxt = BW'(1);
                    pop_nxt   = ONE << sel_idx;
                end
            end
            GRANT: begin
                if (almost_full_in) begin
                    // Park the pointer on the interrupted source so it resumes
                    // first once the downstream drains.
                    state_nxt  = IDLE;
                    burst_nxt  = '0;
                    rr_ptr_nxt = grant_idx;
                end else if (grant_ok && (burst < BW'(BURST))) begin
                    burst_nxt = burst + BW'(1);
                    pop_nxt   = grant_oh;
                end else begin
                    // Rotation costs one pop-free cycle; IDLE re-picks from
                    // the advanced pointer with fresh flags.
                    state_nxt  = IDLE;
                    burst_nxt  = '0;
                    rr_ptr_nxt = next_ptr;
                    if (sel_found) begin
                        grant_nxt = sel_idx;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM, grant, pointer, burst counter and registered pop strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            burst     <= '0;
            pop_out   <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst     <= burst_nxt;
            pop_out   <= pop_nxt;
        end
    end

    // Select the slice of the source that was popped last cycle.
    always_comb begin
        cap_word = '0;
        for (int i = 0; i < N; i++) begin
            if (pipe_idx == IW'(i)) begin
                cap_word = data_in[i*W +: W];
            end
        end
    end

    // Pop-to-push pipeline: remember which source was popped, capture its
    // word next cycle, push it the cycle after, and count every push.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld  <= 1'b0;
            pipe_idx  <= '0;
            push_out  <= 1'b0;
            data_out  <= '0;
            fwd_count <= '0;
        end else begin
            pipe_vld <= |pop_out;
            pipe_idx <= grant_idx;
            push_out <= pipe_vld;
            if (pipe_vld) begin
                data_out <= cap_word;
            end
            if (push_out) begin
                fwd_count <= fwd_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_referee.sv
// Directed bench for rr_referee: behavioural source FIFOs, expected-word
// queue for downstream pushes, hand-derived per-cycle pop/push/grant tables.
module tb_rr_referee;

    localparam int N = 4;
    localparam int W = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   empty_in;
    logic [N-1:0]   almost_empty_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   pop_out;
    logic           almost_full_in;
    logic           push_out;
    logic [W-1:0]   data_out;
    logic [2:0]     grant_idx;
    logic [15:0]    fwd_count;

    int cnt [N];
    int seq [N];
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // Expected per-cycle behaviour with all four sources loaded, BURST=4.
    logic [N-1:0] t3_pop [22] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                  4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                                  4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
                                  4'h8, 4'h8, 4'h8, 4'h8, 4'h0,
                                  4'h1, 4'h1};
    logic         t3_push [22] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b0};
    logic [2:0]   t3_grant [22] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                                    3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
                                    3'd2, 3'd2, 3'd2, 3'd2, 3'd3,
                                    3'd3, 3'd3, 3'd3, 3'd3, 3'd0,
                                    3'd0, 3'd0};

    // Clock generation.
    always #5 clk = ~clk;

    rr_referee dut (
        .clk             (clk),
        .reset           (reset),
        .empty_in        (empty_in),
        .almost_empty_in (almost_empty_in),
        .data_in         (data_in),
        .pop_out         (pop_out),
        .almost_full_in  (almost_full_in),
        .push_out        (push_out),
        .data_out        (data_out),
        .grant_idx       (grant_idx),
        .fwd_count       (fwd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic update_flags();
        for (int i = 0; i < N; i++) begin
            empty_in[i]        = (cnt[i] == 0);
            almost_empty_in[i] = (cnt[i] <= 1);
        end
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        for (int i = 0; i < N; i++) seq[i] = 0;
        update_flags();
    endtask

    // One clock; the source FIFOs react to the pop seen during the cycle.
    // Word k (from 1) of source i is i*256 + k.
    task automatic tick();
        logic [N-1:0] p;
        p = pop_out;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (p[i] === 1'b1) begin
                if (cnt[i] > 0) begin
                    seq[i]++;
                    cnt[i]--;
                    data_in[i*W +: W] = W'(i * 256 + seq[i]);
                end else begin
                    check("pop_of_empty", 32'(p[i]), 32'd0);
                end
            end
        end
        update_flags();
    endtask

    // Advance one cycle and check pop/push; pushed words go to the scoreboard.
    task automatic cyc(input string tag, input logic [N-1:0] ep, input logic epush);
        logic [W-1:0] e;
        tick();
        check({tag, "_pop"}, 32'(pop_out), 32'(ep));
        check({tag, "_push"}, 32'(push_out), 32'(epush));
        if (push_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({tag, "_extra_push"}, 32'(push_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_data"}, 32'(data_out), 32'(e));
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        almost_full_in = 1'b0;
        data_in        = '0;
        load(0, 0, 0, 0);
        @(posedge clk);
        #1;
        tick();
        check("rst_pop", 32'(pop_out), 32'd0);
        check("rst_push", 32'(push_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);
        check("rst_fwd", 32'(fwd_count), 32'd0);

        // 1: all sources empty -> nothing moves
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc("t1", 4'h0, 1'b0);
            check("t1_fwd", 32'(fwd_count), 32'd0);
        end

        // 2: only source 2, six words -> 4 pops, gap, 2 pops
        exp_q = {12'h201, 12'h202, 12'h203, 12'h204, 12'h205, 12'h206};
        load(0, 0, 6, 0);
        cyc("t2_c1", 4'h4, 1'b0);
        cyc("t2_c2", 4'h4, 1'b0);
        cyc("t2_c3", 4'h4, 1'b1);
        cyc("t2_c4", 4'h4, 1'b1);
        cyc("t2_c5", 4'h0, 1'b1);
        check("t2_grant_gap", 32'(grant_idx), 32'd2);
        cyc("t2_c6", 4'h4, 1'b1);
        cyc("t2_c7", 4'h4, 1'b0);
        cyc("t2_c8", 4'h0, 1'b1);
        cyc("t2_c9", 4'h0, 1'b1);
        cyc("t2_c10", 4'h0, 1'b0);
        check("t2_fwd", 32'(fwd_count), 32'd6);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: all four sources loaded -> bursts of 4 rotating 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(8, 8, 8, 8);
        exp_q = {12'h001, 12'h002, 12'h003, 12'h004,
                 12'h101, 12'h102, 12'h103, 12'h104,
                 12'h201, 12'h202, 12'h203, 12'h204,
                 12'h301, 12'h302, 12'h303, 12'h304};
        for (int k = 0; k < 22; k++) begin
            cyc("t3", t3_pop[k], t3_push[k]);
            check("t3_grant", 32'(grant_idx), 32'(t3_grant[k]));
        end
        check("t3_fwd", 32'(fwd_count), 32'd16);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: almost_full while popping source 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(0, 8, 0, 0);
        exp_q = {12'h101, 12'h102, 12'h103};
        cyc("t4_d1", 4'h2, 1'b0);
        check("t4_grant", 32'(grant_idx), 32'd1);
        cyc("t4_d2", 4'h2, 1'b0);
        almost_full_in = 1'b1;
        cyc("t4_d3", 4'h0, 1'b1);
        cyc("t4_d4", 4'h0, 1'b1);
        cyc("t4_d5", 4'h0, 1'b0);
        cyc("t4_d6", 4'h0, 1'b0);
        almost_full_in = 1'b0;
        cyc("t4_d7", 4'h2, 1'b0);
        check("t4_resume_grant", 32'(grant_idx), 32'd1);
        cyc("t4_d8", 4'h2, 1'b0);
        cyc("t4_d9", 4'h2, 1'b1);

        // 5: source 3 holds a single word -> exactly one pop
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(0, 0, 0, 1);
        exp_q = {12'h301};
        cyc("t5_d1", 4'h8, 1'b0);
        check("t5_grant", 32'(grant_idx), 32'd3);
        cyc("t5_d2", 4'h0, 1'b0);
        cyc("t5_d3", 4'h0, 1'b1);
        cyc("t5_d4", 4'h0, 1'b0);
        check("t5_fwd", 32'(fwd_count), 32'd1);

        // 6: reset while words are in flight drops them
        exp_q = {};
        load(8, 0, 0, 0);
        cyc("t6_d1", 4'h1, 1'b0);
        cyc("t6_d2", 4'h1, 1'b0);
        check("t6_fwd_before", 32'(fwd_count), 32'd1);
        reset = 1'b1;
        cyc("t6_d3", 4'h0, 1'b0);
        check("t6_rst_data", 32'(data_out), 32'd0);
        check("t6_rst_grant", 32'(grant_idx), 32'd0);
        check("t6_rst_fwd", 32'(fwd_count), 32'd0);
        reset = 1'b0;
        exp_q = {12'h003};
        cyc("t6_d4", 4'h1, 1'b0);
        check("t6_grant", 32'(grant_idx), 32'd0);
        cyc("t6_d5", 4'h1, 1'b0);
        cyc("t6_d6", 4'h1, 1'b1);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
